// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - Operand/command and HI/LO result bundle between EX stage and the MDU
//
// Purpose: groups the multiply/divide unit's command inputs and status/result
// outputs so the EX stage and hazard unit connect through one port.
// Signals:
//   start  1   launch op this cycle (single-cycle pulse from ID/EX)
//   op     3   0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6-7 reserved
//   A      32  rs operand (forwarded)
//   B      32  rt operand (forwarded)
//   busy   1   operation in progress
//   HI     32  architectural HI register
//   LO     32  architectural LO register
// Modports: master = pipeline side (drives command), slave = MDU side.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - Multi-cycle multiply/divide unit holding the HI/LO registers
//
// Purpose: computes mult/multu/div/divu results at the start edge, parks them
// in hi_tmp/lo_tmp, and publishes them to HI/LO after a fixed busy window so the
// hazard unit sees a realistic latency. mthi/mtlo write HI/LO directly.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset (priority over everything)
//   bus    slave modport of mdu_if (start/op/A/B in, busy/HI/LO out)
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d;
  logic [31:0]   lo_tmp_q, lo_tmp_d;

  // Arithmetic datapath, evaluated on the current operands.
  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_abs, b_abs, b_sdiv, b_udiv;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;

  assign a      = bus.A;
  assign b      = bus.B;
  assign b_zero = (b == 32'd0);

  // Sign-extending to 64 bits makes the low 64 bits of the product the
  // correct two's-complement signed result.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as
  // quotient 0x80000000, remainder 0.
  assign a_abs  = a[31] ? (~a + 32'd1) : a;
  assign b_abs  = b[31] ? (~b + 32'd1) : b;
  // A zero divisor never reaches HI/LO; substitute 1 to keep the divider defined.
  assign b_sdiv = b_zero ? 32'd1 : b_abs;
  assign b_udiv = b_zero ? 32'd1 : b;
  assign q_mag  = a_abs / b_sdiv;
  assign r_mag  = a_abs % b_sdiv;
  assign q_s    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = a / b_udiv;
  assign r_u    = a % b_udiv;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0: begin
              {hi_tmp_d, lo_tmp_d} = prod_s;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            3'd1: begin
              {hi_tmp_d, lo_tmp_d} = prod_u;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            3'd2: begin
              // Divide by zero republishes the pre-op HI/LO at completion.
              hi_tmp_d = b_zero ? hi_q : r_s;
              lo_tmp_d = b_zero ? lo_q : q_s;
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = BUSY;
            end
            3'd3: begin
              hi_tmp_d = b_zero ? hi_q : r_u;
              lo_tmp_d = b_zero ? lo_q : q_u;
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = BUSY;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // start is ignored here; the hazard unit never issues while busy.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - Self-checking bench for the multiply/divide unit
module tb_mdu;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference HI/LO state and expected busy length.
  logic [31:0] mh, ml;
  int          mcyc;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain 64-bit arithmetic on the architectural rules.
  task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mcyc = 0;
    case (op)
      3'd0: begin sp = sa * sb; mh = sp[63:32]; ml = sp[31:0]; mcyc = 5; end
      3'd1: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        mh = up[63:32]; ml = up[31:0]; mcyc = 5;
      end
      3'd2: begin
        mcyc = 10;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; ml = sq[31:0]; mh = sr[31:0]; end
      end
      3'd3: begin
        mcyc = 10;
        if (b != 0) begin ml = a / b; mh = a % b; end
      end
      3'd4: mh = a;
      3'd5: ml = a;
      default: ;
    endcase
  endtask

  // Issues one op and measures the busy window; also notes whether HI/LO
  // stayed put while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int cyc, output logic held);
    logic [31:0] pre_hi, pre_lo;
    @(negedge clk);
    pre_hi = bus.HI;
    pre_lo = bus.LO;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom;
    @(negedge clk);
    cyc  = 0;
    held = 1'b1;
    while (bus.busy && cyc < 40) begin
      if (bus.HI !== pre_hi || bus.LO !== pre_lo) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
    hi = bus.HI;
    lo = bus.LO;
  endtask

  logic [31:0] r_hi, r_lo;
  int          r_cyc, n, bad;
  logic        r_held;
  logic [31:0] ra, rb, oa, ob;
  logic [2:0]  rop;

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);

    vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd4, 32'h11111111, 32'h0,        32'h11111111, 32'h80000000, 0};
    vecs[6] = '{3'd5, 32'h22222222, 32'h0,        32'h11111111, 32'h22222222, 0};
    vecs[7] = '{3'd3, 32'h12345678, 32'h00000000, 32'h11111111, 32'h22222222, 10};
    vecs[8] = '{3'd4, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h22222222, 0};
    vecs[9] = '{3'd6, 32'hCAFEF00D, 32'h1,        32'hDEADBEEF, 32'h22222222, 0};

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_cyc, r_held);
      check($sformatf("vec%0d_cycles", i), 32'(r_cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i), r_hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), r_lo, vecs[i].exp_lo);
      if (vecs[i].exp_cyc > 0)
        check($sformatf("vec%0d_held", i), {31'd0, r_held}, 32'd1);
    end
    mh = 32'hDEADBEEF;
    ml = 32'h22222222;

    // mtlo pulsed on busy cycle 2 of a mult, with operands changed: ignored.
    oa = 32'h12345678; ob = 32'h9ABCDEF0;
    model_step(3'd0, oa, ob);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = oa; bus.B = ob;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == 2) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'd5; bus.B = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.A = 32'h0BADF00D; bus.B = 32'h0;
      end
      @(negedge clk);
    end
    check("ign_cycles", 32'(n), 32'd5);
    check("ign_hi", bus.HI, mh);
    check("ign_lo", bus.LO, ml);

    // Reset during busy cycle 3 of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_hi", bus.HI, 32'd0);
    check("rst_mid_lo", bus.LO, 32'd0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy || bus.HI != 0 || bus.LO != 0) bad++;
    end
    check("rst_no_late_update", 32'(bad), 32'd0);
    mh = 32'd0; ml = 32'd0;
    model_step(3'd0, 32'hFFFF0003, 32'h00000007);
    run_op(3'd0, 32'hFFFF0003, 32'h00000007, r_hi, r_lo, r_cyc, r_held);
    check("post_rst_cycles", 32'(r_cyc), 32'(mcyc));
    check("post_rst_hi", r_hi, mh);
    check("post_rst_lo", r_lo, ml);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      model_step(rop, ra, rb);
      run_op(rop, ra, rb, r_hi, r_lo, r_cyc, r_held);
      check($sformatf("rnd%0d_op%0d_cycles", i, rop), 32'(r_cyc), 32'(mcyc));
      check($sformatf("rnd%0d_op%0d_hi", i, rop), r_hi, mh);
      check($sformatf("rnd%0d_op%0d_lo", i, rop), r_lo, ml);
      if (mcyc > 0)
        check($sformatf("rnd%0d_held", i), {31'd0, r_held}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage, alongside the ALU.
- Takes rs/rt operands after forwarding: A from the RD1 path, B from RD2 (register operand, never imm32).
- Holds the architectural HI/LO registers.
- HI/LO are consumed by the EX-stage result select for mfhi/mflo.
- busy is consumed by the hazard unit to stall the pipeline while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch op this cycle; single-cycle pulse from ID/EX.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6-7 reserved (no effect).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  operation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset: every clk edge with reset=1 sets HI=0, LO=0, busy=0, counter=0, and discards any pending result. Reset has priority over all other inputs, including mid-operation.
- FSM states: IDLE, BUSY.
- IDLE:
  - start=1 with op 0-3: latch the computed result into internal hi_tmp/lo_tmp (operands sampled this edge). Load counter with MULT_CYCLES or DIV_CYCLES. Go to BUSY; busy=1 from the next cycle.
  - start=1 with op 4 (mthi): HI<=A at this edge; stay IDLE; busy stays 0.
  - start=1 with op 5 (mtlo): LO<=A at this edge; stay IDLE; busy stays 0.
  - start=1 with op 6-7: no state change.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter goes 1->0: HI<=hi_tmp, LO<=lo_tmp, busy<=0, go to IDLE.
  - busy is high for exactly N consecutive cycles, N = MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible the same cycle busy falls.
- start while busy=1 (any op, including mthi/mtlo) is ignored; the hazard unit guarantees this never happens legally.
- HI/LO hold their old values throughout BUSY. They change only at completion, on mthi/mtlo, or on reset.
- Arithmetic:
  - mult: {HI,LO} = signed 32x32 -> 64-bit product.
  - multu: {HI,LO} = unsigned 32x32 -> 64-bit product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, same sign as dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (B=0, div or divu): busy runs the full DIV_CYCLES; HI and LO keep their pre-op values.
- Operands are sampled only at the start edge; A/B changes during BUSY have no effect.
- No exceptions are raised and there is no overflow flag.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002 -> busy high for exactly 5 cycles; as busy falls, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. During BUSY, HI/LO hold their previous values.
- div, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=2 -> LO=3, HI=1.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload mthi 0x11111111 and mtlo 0x22222222, then divu with B=0 -> busy for 10 cycles; afterwards HI=0x11111111, LO=0x22222222.
- mthi A=0xDEADBEEF -> HI=0xDEADBEEF the next cycle; busy never asserts; LO unchanged.
- Issue mult, then on busy cycle 2 pulse start with mtlo A=5 and change A/B -> mtlo ignored; final result matches the original operands.
- reset=1 at busy cycle 3 of a div -> next cycle busy=0, HI=0, LO=0. No later update occurs; a new mult started after reset completes normally.
